// File: rtl/mult_seq32_if.sv
// rtl/mult_seq32_if.sv - start/result and HI/LO write bus between control unit and mult_seq32
interface mult_seq32_if;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_seq32.sv
// rtl/mult_seq32.sv - sequential 32x32 MULT/MULTU built on one shared 16x16 multiplier core
module multiplier (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] z
);
  assign z = a * b;
endmodule

module mult_seq32 (
  input  logic         clk,
  input  logic         rst_n,
  mult_seq32_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, FIX} state_t;

  state_t      state_q, state_d;
  logic [31:0] ma_q, ma_d;
  logic [31:0] mb_q, mb_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_z;
  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_z64;

  multiplier u_core (.a(mul_a), .b(mul_b), .z(mul_z));

  // Magnitudes are taken as 32-bit unsigned, so |0x80000000| stays 0x80000000.
  assign abs_a   = (bus.is_signed && bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
  assign abs_b   = (bus.is_signed && bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;
  assign mul_z64 = {32'd0, mul_z};

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    mul_a   = 16'd0;
    mul_b   = 16'd0;
    case (state_q)
      IDLE: begin
        if (bus.wr_hi) hi_d = bus.wr_data;
        if (bus.wr_lo) lo_d = bus.wr_data;
        if (bus.start) begin
          ma_d    = abs_a;
          mb_d    = abs_b;
          neg_d   = bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
          acc_d   = 64'd0;
          state_d = P0;
        end
      end
      P0: begin
        mul_a   = ma_q[15:0];
        mul_b   = mb_q[15:0];
        acc_d   = acc_q + mul_z64;
        state_d = P1;
      end
      P1: begin
        mul_a   = ma_q[31:16];
        mul_b   = mb_q[15:0];
        acc_d   = acc_q + (mul_z64 << 16);
        state_d = P2;
      end
      P2: begin
        mul_a   = ma_q[15:0];
        mul_b   = mb_q[31:16];
        acc_d   = acc_q + (mul_z64 << 16);
        state_d = P3;
      end
      P3: begin
        mul_a   = ma_q[31:16];
        mul_b   = mb_q[31:16];
        acc_d   = acc_q + (mul_z64 << 32);
        state_d = FIX;
      end
      FIX: begin
        {hi_d, lo_d} = neg_q ? (~acc_q + 64'd1) : acc_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ma_q    <= 32'd0;
      mb_q    <= 32'd0;
      neg_q   <= 1'b0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
